// File: rtl/usb_status_tx.sv
// usb_status_tx: snapshots front-end/scan/link state and writes a 32-byte status packet into the USB TX FIFO.
// Byte 31 carries a two's-complement checksum when USB_STATUS_TX_CSUM_EN is defined, otherwise 0x00.
module usb_status_tx #(
  parameter int unsigned PERIOD_CYCLES = 1_000_000
) (
  input  logic        clk_100M,
  input  logic        rst,
  output logic        usb_wr_clk,
  output logic        usb_wr_valid,
  output logic [7:0]  usb_writedata,
  input  logic [7:0]  usb_tx_free,
  input  logic        cont_en,
  input  logic [15:0] cont_gain,
  input  logic [15:0] cont_off,
  input  logic        scan_busy,
  input  logic [31:0] line_count,
  input  logic        ovf_flag,
  input  logic        tx_req,
  output logic        tx_busy,
  output logic        tx_done
);

  typedef enum logic [1:0] {IDLE, WAIT_SPACE, SEND} state_e;

  localparam logic [31:0] TIMER_LAST = PERIOD_CYCLES - 1;

  state_e      state_q, state_d;
  logic [31:0] timer_q;
  logic        tick, trig, start;
  logic        pending_q;
  logic [7:0]  drop_q, drop_snap_q;
  logic [7:0]  seq_q;
  logic [4:0]  idx_q;
  logic        done_q;
  logic        en_q, busy_q, ovf_q;
  logic [15:0] gain_q, off_q;
  logic [31:0] lc_q;
  logic [7:0]  field_byte;
  logic [7:0]  csum_byte;

  assign usb_wr_clk = clk_100M;

  // Free-running period timer; PERIOD_CYCLES of 0 parks it and suppresses ticks.
  always_ff @(posedge clk_100M) begin
    if (rst || PERIOD_CYCLES == 0 || timer_q == TIMER_LAST) timer_q <= '0;
    else timer_q <= timer_q + 32'd1;
  end

  assign tick  = (PERIOD_CYCLES != 0) && (timer_q == TIMER_LAST);
  assign trig  = tx_req | tick;
  assign start = (state_q == IDLE) && (trig || pending_q);

  always_ff @(posedge clk_100M) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (trig || pending_q) state_d = WAIT_SPACE;
      WAIT_SPACE: if (usb_tx_free >= 8'd32) state_d = SEND;
      SEND:       if (idx_q == 5'd31) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      pending_q   <= 1'b0;
      drop_q      <= '0;
      drop_snap_q <= '0;
      seq_q       <= '0;
      idx_q       <= '0;
      done_q      <= 1'b0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
      gain_q      <= '0;
      off_q       <= '0;
      lc_q        <= '0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        en_q        <= cont_en;
        busy_q      <= scan_busy;
        ovf_q       <= ovf_flag;
        gain_q      <= cont_gain;
        off_q       <= cont_off;
        lc_q        <= line_count;
        drop_snap_q <= drop_q;
        pending_q   <= 1'b0;
        drop_q      <= '0;
      end else if (state_q != IDLE && trig) begin
        // Only one packet can be queued; further requests are counted as drops.
        if (!pending_q)            pending_q <= 1'b1;
        else if (drop_q != 8'hFF)  drop_q    <= drop_q + 8'd1;
      end
      if (state_q == WAIT_SPACE) idx_q <= '0;
      else if (state_q == SEND)  idx_q <= idx_q + 5'd1;
      if (state_q == SEND && idx_q == 5'd31) begin
        done_q <= 1'b1;
        seq_q  <= seq_q + 8'd1;
      end
    end
  end

  always_comb begin
    field_byte = 8'h00;
    case (idx_q)
      5'd0:    field_byte = 8'hA5;
      5'd1:    field_byte = seq_q;
      5'd2:    field_byte = {5'b0, ovf_q, busy_q, en_q};
      5'd3:    field_byte = gain_q[7:0];
      5'd4:    field_byte = gain_q[15:8];
      5'd5:    field_byte = off_q[7:0];
      5'd6:    field_byte = off_q[15:8];
      5'd7:    field_byte = lc_q[7:0];
      5'd8:    field_byte = lc_q[15:8];
      5'd9:    field_byte = lc_q[23:16];
      5'd10:   field_byte = lc_q[31:24];
      5'd11:   field_byte = drop_snap_q;
      default: field_byte = 8'h00;
    endcase
  end

`ifdef USB_STATUS_TX_CSUM_EN
  logic [7:0] csum_q;

  // Running sum of bytes already sent; negated it makes the whole packet sum to zero.
  always_ff @(posedge clk_100M) begin
    if (rst || state_q != SEND) csum_q <= '0;
    else                        csum_q <= csum_q + field_byte;
  end

  assign csum_byte = 8'h00 - csum_q;
`else
  assign csum_byte = 8'h00;
`endif

  always_comb begin
    usb_wr_valid  = (state_q == SEND);
    tx_busy       = (state_q != IDLE);
    tx_done       = done_q;
    usb_writedata = 8'h00;
    if (state_q == SEND) usb_writedata = (idx_q == 5'd31) ? csum_byte : field_byte;
  end

endmodule

// File: tb/tb_usb_status_tx.sv
// Bench for usb_status_tx: one instance with periodic triggering off, one with a 100-cycle period.
`timescale 1ns/1ps
module tb_usb_status_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst_p, tx_req, tx_req_p;
  logic [7:0]  usb_tx_free;
  logic        cont_en, scan_busy, ovf_flag;
  logic [15:0] cont_gain, cont_off;
  logic [31:0] line_count;

  logic       a_wr_clk, a_valid, a_busy, a_done;
  logic [7:0] a_data;
  logic       p_wr_clk, p_valid, p_busy, p_done;
  logic [7:0] p_data;

  usb_status_tx #(.PERIOD_CYCLES(0)) dut_a (
    .clk_100M(clk), .rst(rst), .usb_wr_clk(a_wr_clk), .usb_wr_valid(a_valid),
    .usb_writedata(a_data), .usb_tx_free(usb_tx_free), .cont_en(cont_en),
    .cont_gain(cont_gain), .cont_off(cont_off), .scan_busy(scan_busy),
    .line_count(line_count), .ovf_flag(ovf_flag), .tx_req(tx_req),
    .tx_busy(a_busy), .tx_done(a_done)
  );

  usb_status_tx #(.PERIOD_CYCLES(100)) dut_p (
    .clk_100M(clk), .rst(rst_p), .usb_wr_clk(p_wr_clk), .usb_wr_valid(p_valid),
    .usb_writedata(p_data), .usb_tx_free(usb_tx_free), .cont_en(cont_en),
    .cont_gain(cont_gain), .cont_off(cont_off), .scan_busy(scan_busy),
    .line_count(line_count), .ovf_flag(ovf_flag), .tx_req(tx_req_p),
    .tx_busy(p_busy), .tx_done(p_done)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0] exp_seq;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitors: record every written byte with the cycle it was on the bus.
  logic [7:0] a_bytes[$];
  int         a_vcyc[$];
  int         a_done_n = 0;
  int         a_done_cyc = 0;
  logic [7:0] p_bytes[$];
  int         p_vcyc[$];

  always @(negedge clk) begin
    if (a_valid === 1'b1) begin a_bytes.push_back(a_data); a_vcyc.push_back(cyc); end
    if (a_done === 1'b1) begin a_done_n++; a_done_cyc = cyc; end
    if (p_valid === 1'b1) begin p_bytes.push_back(p_data); p_vcyc.push_back(cyc); end
  end

  // Reference packet as the host's 256-bit little-endian word.
  function automatic logic [255:0] model_pkt(input logic [7:0] seq, input logic [7:0] drop);
    logic [255:0] w;
    logic [7:0]   s;
    w = '0;
    w[7:0]    = 8'hA5;
    w[15:8]   = seq;
    w[23:16]  = {5'b0, ovf_flag, scan_busy, cont_en};
    w[39:24]  = cont_gain;
    w[55:40]  = cont_off;
    w[87:56]  = line_count;
    w[95:88]  = drop;
    s = 8'h00;
    for (int i = 0; i < 31; i++) s = s + w[8*i +: 8];
`ifdef USB_STATUS_TX_CSUM_EN
    w[255:248] = 8'h00 - s;
`endif
    return w;
  endfunction

  function automatic logic [255:0] a_word(input int base);
    logic [255:0] w;
    w = '0;
    for (int i = 0; i < 32; i++) if (base + i < a_bytes.size()) w[8*i +: 8] = a_bytes[base + i];
    return w;
  endfunction

  function automatic logic [255:0] p_word(input int base);
    logic [255:0] w;
    w = '0;
    for (int i = 0; i < 32; i++) if (base + i < p_bytes.size()) w[8*i +: 8] = p_bytes[base + i];
    return w;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic randomize_fields();
    cont_en    = 1'($urandom_range(0, 1));
    scan_busy  = 1'($urandom_range(0, 1));
    ovf_flag   = 1'($urandom_range(0, 1));
    cont_gain  = 16'($urandom);
    cont_off   = 16'($urandom);
    line_count = $urandom;
  endtask

  task automatic pulse_req(output int t);
    tx_req = 1'b1;
    step();
    tx_req = 1'b0;
    t = cyc;
  endtask

  task automatic wait_a_bytes(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (a_bytes.size() < n && k < budget) begin step(); k++; end
    ok = (a_bytes.size() >= n);
  endtask

  task automatic clear_a();
    a_bytes.delete();
    a_vcyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; rst_p = 1'b1; tx_req = 1'b0; tx_req_p = 1'b0;
    usb_tx_free = 8'd64;
    cont_en = 0; scan_busy = 0; ovf_flag = 0; cont_gain = 0; cont_off = 0; line_count = 0;
    repeat (3) step();
    checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", a_valid); end
    checks++; if (a_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", a_data); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
    checks++; if (a_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", a_done); end
    checks++; if (a_wr_clk !== clk) begin failures++; $display("FAIL wr_clk got=%b exp=%b", a_wr_clk, clk); end
    rst = 1'b0;
    clear_a();
    repeat (20) step();
    checks++; if (a_bytes.size() != 0) begin failures++; $display("FAIL no_periodic got=%0d bytes exp=0", a_bytes.size()); end
    exp_seq = 8'h00;
  endtask

  task automatic test_single();
    logic [255:0] exp, obs;
    int t, d0, k;
    cont_en = 1'b1; cont_gain = 16'h1234; cont_off = 16'h5678; scan_busy = 1'b0;
    line_count = 32'h10; ovf_flag = 1'b0; usb_tx_free = 8'd64;
    exp = model_pkt(exp_seq, 8'h00);
    clear_a();
    d0 = a_done_n;
    pulse_req(t);
    checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", a_busy); end
    checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL single_wait_valid got=%b exp=0", a_valid); end
    k = 0;
    while (a_done_n == d0 && k < 60) begin step(); k++; end
    repeat (5) step();
    checks++; if (a_done_n - d0 != 1) begin failures++; $display("FAIL single_done_count got=%0d exp=1", a_done_n - d0); end
    checks++; if (a_bytes.size() != 32) begin failures++; $display("FAIL single_len got=%0d exp=32", a_bytes.size()); end
    obs = a_word(0);
    checks++; if (obs !== exp) begin failures++; $display("FAIL single_word got=%h exp=%h", obs, exp); end
    checks++; if (obs[95:0] !== 96'h00000000_1056781234_0100A5) begin failures++; $display("FAIL single_hdr got=%h exp=000000001056781234 0100a5", obs[95:0]); end
    checks++; if (obs[247:96] !== '0) begin failures++; $display("FAIL single_pad got=%h exp=0", obs[247:96]); end
`ifdef USB_STATUS_TX_CSUM_EN
    checks++; if (obs[255:248] !== 8'h36) begin failures++; $display("FAIL single_csum got=%h exp=36", obs[255:248]); end
`else
    checks++; if (obs[255:248] !== 8'h00) begin failures++; $display("FAIL single_csum got=%h exp=00", obs[255:248]); end
`endif
    if (a_vcyc.size() == 32) begin
      checks++; if (a_vcyc[0] != t + 1) begin failures++; $display("FAIL single_first_cyc got=%0d exp=%0d", a_vcyc[0], t + 1); end
      checks++; if (a_vcyc[31] != t + 32) begin failures++; $display("FAIL single_last_cyc got=%0d exp=%0d", a_vcyc[31], t + 32); end
    end
    checks++; if (a_done_cyc != t + 33) begin failures++; $display("FAIL single_done_cyc got=%0d exp=%0d", a_done_cyc, t + 33); end
    exp_seq++;
  endtask

  task automatic test_random_packets();
    logic [255:0] exp, obs;
    int t;
    bit ok;
    for (int n = 0; n < 8; n++) begin
      randomize_fields();
      usb_tx_free = 8'($urandom_range(32, 255));
      exp = model_pkt(exp_seq, 8'h00);
      clear_a();
      pulse_req(t);
      randomize_fields();
      wait_a_bytes(32, 60, ok);
      repeat (3) step();
      checks++; if (!ok || a_bytes.size() != 32) begin failures++; $display("FAIL rand_len[%0d] got=%0d exp=32", n, a_bytes.size()); end
      obs = a_word(0);
      checks++; if (obs !== exp) begin failures++; $display("FAIL rand_word[%0d] got=%h exp=%h", n, obs, exp); end
      if (a_vcyc.size() > 0) begin
        checks++; if (a_vcyc[0] != t + 1) begin failures++; $display("FAIL rand_start[%0d] got=%0d exp=%0d", n, a_vcyc[0], t + 1); end
      end
      exp_seq++;
    end
  endtask

  task automatic test_space_wait();
    logic [255:0] exp, obs;
    int t, n, bad;
    bit ok;
    randomize_fields();
    usb_tx_free = 8'($urandom_range(0, 31));
    exp = model_pkt(exp_seq, 8'h00);
    clear_a();
    pulse_req(t);
    n = $urandom_range(5, 30);
    bad = 0;
    repeat (n) begin
      step();
      if (a_busy !== 1'b1 || a_valid !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL space_hold got=%0d bad cycles exp=0", bad); end
    checks++; if (a_bytes.size() != 0) begin failures++; $display("FAIL space_nobytes got=%0d exp=0", a_bytes.size()); end
    usb_tx_free = 8'd32;
    step();
    checks++; if (a_valid !== 1'b1) begin failures++; $display("FAIL space_start got=%b exp=1", a_valid); end
    repeat (4) step();
    usb_tx_free = 8'd0;
    wait_a_bytes(32, 60, ok);
    repeat (3) step();
    checks++; if (!ok || a_bytes.size() != 32) begin failures++; $display("FAIL space_len got=%0d exp=32", a_bytes.size()); end
    obs = a_word(0);
    checks++; if (obs !== exp) begin failures++; $display("FAIL space_word got=%h exp=%h", obs, exp); end
    usb_tx_free = 8'd64;
    exp_seq++;
  endtask

  task automatic test_coalesce();
    logic [255:0] e1, e2, e3, obs;
    int t, t2;
    bit ok;
    randomize_fields();
    usb_tx_free = 8'd64;
    e1 = model_pkt(exp_seq, 8'h00);
    e2 = model_pkt(exp_seq + 8'd1, 8'h02);
    e3 = model_pkt(exp_seq + 8'd2, 8'h00);
    clear_a();
    pulse_req(t);
    repeat (3) step();
    pulse_req(t2);
    repeat (5) step();
    pulse_req(t2);
    repeat (5) step();
    pulse_req(t2);
    wait_a_bytes(64, 150, ok);
    checks++; if (!ok) begin failures++; $display("FAIL coal_followup got=%0d bytes exp=64", a_bytes.size()); end
    obs = a_word(0);
    checks++; if (obs !== e1) begin failures++; $display("FAIL coal_first got=%h exp=%h", obs, e1); end
    obs = a_word(32);
    checks++; if (obs !== e2) begin failures++; $display("FAIL coal_second got=%h exp=%h", obs, e2); end
    if (a_vcyc.size() >= 64) begin
      checks++; if (a_vcyc[32] - a_vcyc[31] != 3) begin failures++; $display("FAIL coal_gap got=%0d exp=3", a_vcyc[32] - a_vcyc[31]); end
    end
    repeat (50) step();
    checks++; if (a_bytes.size() != 64) begin failures++; $display("FAIL coal_extra got=%0d bytes exp=64", a_bytes.size()); end
    pulse_req(t);
    wait_a_bytes(96, 60, ok);
    obs = a_word(64);
    checks++; if (!ok || obs !== e3) begin failures++; $display("FAIL coal_third got=%h exp=%h", obs, e3); end
    repeat (3) step();
    exp_seq = exp_seq + 8'd3;
  endtask

  task automatic test_drop_saturate();
    logic [255:0] e1, e2, obs;
    int t;
    bit ok;
    randomize_fields();
    usb_tx_free = 8'd0;
    e1 = model_pkt(exp_seq, 8'h00);
    e2 = model_pkt(exp_seq + 8'd1, 8'hFF);
    clear_a();
    pulse_req(t);
    tx_req = 1'b1;
    repeat (300) step();
    tx_req = 1'b0;
    usb_tx_free = 8'd64;
    wait_a_bytes(64, 150, ok);
    repeat (3) step();
    obs = a_word(0);
    checks++; if (!ok || obs !== e1) begin failures++; $display("FAIL sat_first got=%h exp=%h", obs, e1); end
    obs = a_word(32);
    checks++; if (obs !== e2) begin failures++; $display("FAIL sat_second got=%h exp=%h", obs, e2); end
    exp_seq = exp_seq + 8'd2;
  endtask

  task automatic test_reset_mid();
    logic [255:0] exp, obs;
    int t, d0, sz;
    bit ok;
    randomize_fields();
    usb_tx_free = 8'd64;
    exp = model_pkt(exp_seq, 8'h00);
    clear_a();
    pulse_req(t);
    repeat (2) step();
    pulse_req(t);
    wait_a_bytes(11, 40, ok);
    checks++; if (!ok || a_data !== exp[87:80]) begin failures++; $display("FAIL mid_byte10 got=%h exp=%h", a_data, exp[87:80]); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", a_valid); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", a_busy); end
    checks++; if (a_data !== 8'h00) begin failures++; $display("FAIL mid_data got=%h exp=00", a_data); end
    d0 = a_done_n;
    sz = a_bytes.size();
    repeat (40) step();
    checks++; if (a_done_n != d0) begin failures++; $display("FAIL mid_no_done got=%0d exp=%0d", a_done_n, d0); end
    checks++; if (a_bytes.size() != sz) begin failures++; $display("FAIL mid_no_resume got=%0d exp=%0d", a_bytes.size(), sz); end
    exp_seq = 8'h00;
    randomize_fields();
    exp = model_pkt(exp_seq, 8'h00);
    clear_a();
    pulse_req(t);
    wait_a_bytes(32, 60, ok);
    repeat (3) step();
    obs = a_word(0);
    checks++; if (obs[15:8] !== 8'h00) begin failures++; $display("FAIL mid_seq got=%h exp=00", obs[15:8]); end
    checks++; if (!ok || obs !== exp) begin failures++; $display("FAIL mid_word got=%h exp=%h", obs, exp); end
    exp_seq++;
  endtask

  task automatic test_periodic();
    logic [255:0] obs;
    int e0, k, s, bad_gap, bad_run, bad_pkt;
    randomize_fields();
    usb_tx_free = 8'd64;
    p_bytes.delete();
    p_vcyc.delete();
    rst_p = 1'b0;
    e0 = cyc;
    k = 0;
    while (p_bytes.size() < 257 * 32 && k < 257 * 100 + 300) begin step(); k++; end
    checks++; if (p_bytes.size() < 257 * 32) begin failures++; $display("FAIL per_count got=%0d bytes exp=%0d", p_bytes.size(), 257 * 32); end
    else begin
      checks++; if (p_vcyc[0] != e0 + 101) begin failures++; $display("FAIL per_first got=%0d exp=%0d", p_vcyc[0], e0 + 101); end
      bad_gap = 0; bad_run = 0; bad_pkt = 0;
      for (int i = 0; i < 257; i++) begin
        if (i > 0 && p_vcyc[32*i] - p_vcyc[32*(i-1)] != 100) bad_gap++;
        if (p_vcyc[32*i+31] - p_vcyc[32*i] != 31) bad_run++;
        obs = p_word(32 * i);
        if (obs !== model_pkt(8'(i), 8'h00)) bad_pkt++;
      end
      checks++; if (bad_gap != 0) begin failures++; $display("FAIL per_gap got=%0d bad gaps exp=0", bad_gap); end
      checks++; if (bad_run != 0) begin failures++; $display("FAIL per_run got=%0d broken packets exp=0", bad_run); end
      checks++; if (bad_pkt != 0) begin failures++; $display("FAIL per_content got=%0d bad packets exp=0", bad_pkt); end
      checks++; if (p_bytes[255*32+1] !== 8'hFF) begin failures++; $display("FAIL per_seq_ff got=%h exp=ff", p_bytes[255*32+1]); end
      checks++; if (p_bytes[256*32+1] !== 8'h00) begin failures++; $display("FAIL per_seq_wrap got=%h exp=00", p_bytes[256*32+1]); end
      // A request landing on the same edge as a tick must produce a single packet.
      s = p_vcyc[256*32];
      k = 0;
      while (cyc < s + 98 && k < 200) begin step(); k++; end
      tx_req_p = 1'b1;
      step();
      tx_req_p = 1'b0;
      k = 0;
      while (cyc < s + 160 && k < 200) begin step(); k++; end
      checks++; if (p_bytes.size() != 258 * 32) begin failures++; $display("FAIL per_coincide got=%0d bytes exp=%0d", p_bytes.size(), 258 * 32); end
      if (p_vcyc.size() > 257 * 32) begin
        checks++; if (p_vcyc[257*32] != s + 100) begin failures++; $display("FAIL per_coincide_start got=%0d exp=%0d", p_vcyc[257*32], s + 100); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_random_packets();
    test_space_wait();
    test_coalesce();
    test_drop_saturate();
    test_reset_mid();
    test_periodic();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
